// File: rtl/serial_slt_unit.sv
// serial_slt_unit: bit-serial MSB-first set-less-than (SLT) responder.
// Optional macro SLTU_EN adds an unsigned_op port for unsigned compares.
module serial_slt_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SLTU_EN
  input  logic             unsigned_op,
`endif
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] immediate,
  output logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ZERO = '0;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] a_reg, a_reg_n;
  logic [WIDTH-1:0] b_reg, b_reg_n;
  logic             decided, decided_n;
  logic             lt, lt_n;
  logic [WIDTH-1:0] rt_n;
  logic             busy_n;
  logic             done_n;

  logic             a_bit;
  logic             b_bit;
  logic             differ;
  logic             msb_signed;
  logic             bit_lt;
  logic             lt_upd;
  logic             decided_upd;

`ifdef SLTU_EN
  logic             uns_q, uns_n;
  logic             sgn;
  assign sgn = ~uns_q;
`else
  logic             sgn;
  assign sgn = 1'b1;
`endif

  // Decide the current bit: first differing bit fixes the result.
  always_comb begin
    a_bit       = a_reg[cnt];
    b_bit       = b_reg[cnt];
    differ      = a_bit ^ b_bit;
    msb_signed  = (cnt == LAST) && sgn;
    bit_lt      = msb_signed ? a_bit : b_bit;
    lt_upd      = lt;
    decided_upd = decided;
    if (!decided && differ) begin
      lt_upd      = bit_lt;
      decided_upd = 1'b1;
    end
  end

  // Next-state and registered-output logic for the IDLE/RUN sequencer.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    a_reg_n   = a_reg;
    b_reg_n   = b_reg;
    decided_n = decided;
    lt_n      = lt;
    rt_n      = rt;
    busy_n    = busy;
    done_n    = 1'b0;
`ifdef SLTU_EN
    uns_n     = uns_q;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          a_reg_n   = rs;
          b_reg_n   = immediate;
          decided_n = 1'b0;
          lt_n      = 1'b0;
          cnt_n     = LAST;
          busy_n    = 1'b1;
          state_n   = RUN;
`ifdef SLTU_EN
          uns_n     = unsigned_op;
`endif
        end
      end
      RUN: begin
        decided_n = decided_upd;
        lt_n      = lt_upd;
        cnt_n     = cnt - 1'b1;
        if (cnt == ZERO) begin
          rt_n    = {{(WIDTH-1){1'b0}}, lt_upd};
          done_n  = 1'b1;
          busy_n  = 1'b0;
          cnt_n   = LAST;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any compare in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= LAST;
      a_reg   <= '0;
      b_reg   <= '0;
      decided <= 1'b0;
      lt      <= 1'b0;
      rt      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SLTU_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      a_reg   <= a_reg_n;
      b_reg   <= b_reg_n;
      decided <= decided_n;
      lt      <= lt_n;
      rt      <= rt_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef SLTU_EN
      uns_q   <= uns_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_slt_unit.sv
// tb_serial_slt_unit: directed plus random checks of serial_slt_unit
// against an arithmetic reference compare.
module tb_serial_slt_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] rs;
  logic [W-1:0] immediate;
  logic [W-1:0] rt;
  logic         busy;
  logic         done;
  logic         unsigned_op;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_slt_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef SLTU_EN
    .unsigned_op(unsigned_op),
`endif
    .rs(rs),
    .immediate(immediate),
    .rt(rt),
    .busy(busy),
    .done(done)
  );

  function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic u);
    logic r;
    if (u) r = (a < b);
    else   r = ($signed(a) < $signed(b));
    return {{(W-1){1'b0}}, r};
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                     input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic u);
    start       = 1'b1;
    rs          = a;
    immediate   = b;
    unsigned_op = u;
    @(posedge clk);
    #1;
    start     = 1'b0;
    rs        = W'($urandom);
    immediate = W'($urandom);
  endtask

  task automatic wait_done(output int n, output logic busy_ok,
                           input int inject_at);
    n       = 0;
    busy_ok = 1'b1;
    while (!done && n < 3 * W) begin
      if (!busy) busy_ok = 1'b0;
      if (n == inject_at) begin
        start     = 1'b1;
        rs        = '0;
        immediate = W'(1);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic u, input string tag,
                    input int inject_at, input bit chain);
    logic [W-1:0] exp;
    int           n;
    logic         bok;
    unsigned_op = u;
    exp = model(a, b, unsigned_op);
    issue(a, b, u);
    chk(32'(busy), 32'd1, {tag, "_busy_start"});
    wait_done(n, bok, inject_at);
    chk(32'(n), 32'(W), {tag, "_latency"});
    chk(32'(done), 32'd1, {tag, "_done"});
    chk(32'(rt), 32'(exp), {tag, "_rt"});
    chk(32'(busy), 32'd0, {tag, "_busy_end"});
    chk(32'(bok), 32'd1, {tag, "_busy_run"});
    if (!chain) begin
      @(posedge clk);
      #1;
      chk(32'(done), 32'd0, {tag, "_done_pulse"});
      chk(32'(rt), 32'(exp), {tag, "_rt_hold"});
      @(negedge clk);
    end
  endtask

  task automatic quiet(input int cycles, input string tag);
    int extra;
    extra = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk(32'(extra), 32'd0, tag);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         ru;
    reset       = 1'b1;
    start       = 1'b0;
    rs          = '0;
    immediate   = '0;
    unsigned_op = 1'b0;
    #12;
    chk(32'(rt), 32'd0, "rst_rt");
    chk(32'(busy), 32'd0, "rst_busy");
    chk(32'(done), 32'd0, "rst_done");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    op(16'd4, 16'd8, 1'b0, "basic", -1, 1'b0);

    op(16'h1234, 16'h1234, 1'b0, "b2b_eq", -1, 1'b1);
    op(16'd9, 16'd3, 1'b0, "b2b_gt", -1, 1'b1);
    op(16'd3, 16'd9, 1'b0, "b2b_lt", -1, 1'b0);

    op(16'h8000, 16'h7FFF, 1'b0, "s_min_max", -1, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, "s_m1_p1", -1, 1'b0);
    op(16'h0001, 16'hFFFF, 1'b0, "s_p1_m1", -1, 1'b0);

`ifdef SLTU_EN
    op(16'hFFFF, 16'h0001, 1'b1, "u_ff_1", -1, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, "u_off", -1, 1'b0);
    op(16'h8000, 16'h7FFF, 1'b1, "u_min_max", -1, 1'b0);
`endif

    op(16'd9, 16'd3, 1'b0, "ign_start", 4, 1'b0);
    quiet(2 * W, "ign_extra_done");

    op(16'd4, 16'd8, 1'b0, "pre_rst", -1, 1'b0);
    issue(16'd4, 16'd8, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk(32'(rt), 32'd0, "mid_rst_rt");
    chk(32'(busy), 32'd0, "mid_rst_busy");
    chk(32'(done), 32'd0, "mid_rst_done");
    @(negedge clk);
    reset = 1'b0;
    quiet(2 * W, "post_rst_no_done");
    chk(32'(rt), 32'd0, "post_rst_rt");
    op(16'hFFF0, 16'h0010, 1'b0, "post_rst_op", -1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = (i % 6 == 0) ? ra : W'($urandom);
`ifdef SLTU_EN
      ru = 1'($urandom);
`else
      ru = 1'b0;
`endif
      op(ra, rb, ru, "rand", -1, (i % 3) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
